pattern_loader: RTL and testbench

- Writer-side counterpart to the renderer's read port on double_buffer: fills the board memory with an initial pattern (clear, pseudo-random, checkerboard, border) on request.
- Shares the logic write port (addr_w/data_w/wr_en) through a top-level mux selected by busy_out.
- Start/busy/done handshake matches the synchronizer's start/done style, so the synchronizer can sequence a load before the first logic generation.

---
 rtl/pattern_loader.sv | 116 +++++++++++
 tb/tb_pattern_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pattern_loader.sv
// pattern_loader: fills board memory with a clear/random/checkerboard/border pattern on request.
// Optional macro PATTERN_LOADER_DENSITY_EN adds density_in to thin out the random pattern.
module pattern_loader #(
   parameter int ADDR_WIDTH        = 12,
   parameter int NUM_WORDS         = 4096,
   parameter int LOG_WORDS_PER_ROW = 2,
   parameter int NUM_ROWS          = 1024
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [1:0]            mode_in,
   input  logic [31:0]           seed_in,
`ifdef PATTERN_LOADER_DENSITY_EN
   input  logic [1:0]            density_in,
`endif
   input  logic                  ready_in,
   output logic [ADDR_WIDTH-1:0] addr_w_out,
   output logic [31:0]           data_w_out,
   output logic                  wr_en_out,
   output logic                  busy_out,
   output logic                  done_out
);
   localparam int WPR = 1 << LOG_WORDS_PER_ROW;
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(NUM_ROWS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(WPR - 1);

   typedef enum logic [1:0] {IDLE, SEED, FILL, DONE} state_t;

   state_t                  state;
   logic [1:0]              mode;
   logic [31:0]             seed;
   logic [31:0]             lfsr;
   logic [ADDR_WIDTH-1:0]   cnt;
   logic [ADDR_WIDTH-1:0]   row;
   logic [ADDR_WIDTH-1:0]   col;
   logic                    edge_row;
   logic [31:0]             rnd;
   logic [31:0]             lfsr_next;
   logic [31:0]             pattern;
`ifdef PATTERN_LOADER_DENSITY_EN
   logic [1:0]              density;
`endif

   // pattern word for the current counter position and the next LFSR value
   always_comb begin
      row       = cnt >> LOG_WORDS_PER_ROW;
      col       = cnt & LAST_COL;
      edge_row  = (row == '0) || (row == LAST_ROW);
      lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
`ifdef PATTERN_LOADER_DENSITY_EN
      rnd = (density == 2'd0) ? lfsr :
            (density == 2'd1) ? lfsr & {lfsr[20:0], lfsr[31:21]} :
                                lfsr & {lfsr[20:0], lfsr[31:21]} & {lfsr[8:0], lfsr[31:9]};
`else
      rnd = lfsr;
`endif
      pattern = (mode == 2'd0) ? 32'h0 :
                (mode == 2'd1) ? rnd :
                (mode == 2'd2) ? (cnt[LOG_WORDS_PER_ROW] ? 32'hAAAA_AAAA : 32'h5555_5555) :
                edge_row       ? 32'hFFFF_FFFF :
                                 {col == LAST_COL, 30'b0, col == '0};
   end

   // load sequencer: latch request, seed the LFSR, stream words while ready, pulse done
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         mode       <= 2'd0;
         seed       <= 32'h1;
         lfsr       <= 32'h1;
         cnt        <= '0;
         addr_w_out <= '0;
         data_w_out <= 32'h0;
         wr_en_out  <= 1'b0;
         busy_out   <= 1'b0;
         done_out   <= 1'b0;
`ifdef PATTERN_LOADER_DENSITY_EN
         density    <= 2'd0;
`endif
      end else begin
         wr_en_out <= 1'b0;
         done_out  <= 1'b0;
         case (state)
            IDLE: if (start_in && !done_out) begin
               mode  <= mode_in;
               seed  <= (seed_in == 32'h0) ? 32'h1 : seed_in;
`ifdef PATTERN_LOADER_DENSITY_EN
               density <= density_in;
`endif
               state <= SEED;
            end
            SEED: begin
               lfsr     <= seed;
               cnt      <= '0;
               busy_out <= 1'b1;
               state    <= FILL;
            end
            FILL: if (ready_in) begin
               wr_en_out  <= 1'b1;
               addr_w_out <= cnt;
               data_w_out <= pattern;
               lfsr       <= lfsr_next;
               if (cnt == LAST_WORD) state <= DONE;
               else cnt <= cnt + 1'b1;
            end
            DONE: begin
               busy_out <= 1'b0;
               done_out <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader: randomized loads checked against a word-by-word reference model.
module tb_pattern_loader;
   localparam int AW = 6, NW = 16, LW = 2, NR = 4, WPR = 1 << LW;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
   logic [1:0]    mode = 2'd0, density = 2'd0;
   logic [31:0]   seed = 32'h0;
   logic [AW-1:0] addr_w;
   logic [31:0]   data_w;
   logic          wr_en, busy, done;
   logic [31:0]   got [NW];
   int            checks = 0, errors = 0;

   always #5 clk = ~clk;

   pattern_loader #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .LOG_WORDS_PER_ROW(LW), .NUM_ROWS(NR)) dut (
      .clk_in(clk),
      .rst_in(rst),
      .start_in(start),
      .mode_in(mode),
      .seed_in(seed),
`ifdef PATTERN_LOADER_DENSITY_EN
      .density_in(density),
`endif
      .ready_in(ready),
      .addr_w_out(addr_w),
      .data_w_out(data_w),
      .wr_en_out(wr_en),
      .busy_out(busy),
      .done_out(done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] l, input int k);
      return (l << k) | (l >> (32 - k));
   endfunction

   // word i of a load, derived directly from the pattern rules
   function automatic logic [31:0] expect_word(input logic [1:0] m, input logic [31:0] s,
                                               input logic [1:0] d, input int i);
      logic [31:0] l = (s == 32'h0) ? 32'h1 : s;
      int row = i / WPR, col = i % WPR;
      for (int k = 0; k < i; k++) l = step(l);
      case (m)
         2'd0: return 32'h0;
         2'd1: return (d == 2'd0) ? l : (d == 2'd1) ? l & rotl(l, 11) : l & rotl(l, 11) & rotl(l, 23);
         2'd2: return (row % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
         default: begin
            if (row == 0 || row == NR - 1) return 32'hFFFF_FFFF;
            return (col == 0 ? 32'h1 : 32'h0) | (col == WPR - 1 ? 32'h8000_0000 : 32'h0);
         end
      endcase
   endfunction

   task automatic load(input logic [1:0] m, input logic [31:0] s, input bit stall, input bit poke);
      int n = 0, cyc = 0, busy_cyc = 0, done_cnt = 0, last_wr = 0;
      bit prev_ready = 1'b1;
      logic [1:0] d;
      @(negedge clk);
`ifdef PATTERN_LOADER_DENSITY_EN
      density = stall ? 2'($urandom_range(0, 3)) : 2'd0;
`endif
      d = density;
      mode = m; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (done_cnt == 0 && cyc < 200) begin
         prev_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         ready = prev_ready;
         start = poke && cyc == 6;
         if (start) begin mode = ~m; seed = ~s; end
         @(negedge clk);
         start = 1'b0; mode = m; seed = s;
         cyc++;
         if (busy) busy_cyc++;
         if (done) done_cnt++;
         check("wr_en", 64'(wr_en), 64'(cyc >= 2 && prev_ready && n < NW));
         if (wr_en) begin
            check("addr", 64'(addr_w), 64'(n));
            check("data", 64'(data_w), 64'(expect_word(m, s, d, n)));
            if (n < NW) got[n] = data_w;
            n++;
            last_wr = cyc;
         end
      end
      check("done_seen", 64'(done_cnt), 64'd1);
      check("write_count", 64'(n), 64'(NW));
      check("done_cycle", 64'(cyc), 64'(last_wr + 1));
      check("busy_cycles", 64'(busy_cyc), 64'(cyc - 1));
      if (!stall) check("done_latency", 64'(cyc), 64'(NW + 2));
      ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_single", 64'(done), 64'd0);
      @(negedge clk);
      check("start_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      int k;
      @(negedge clk);
      check("rst_addr", 64'(addr_w), 64'd0);
      check("rst_data", 64'(data_w), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      load(2'd0, $urandom, 1'b0, 1'b0);
      load(2'd1, 32'h1, 1'b0, 1'b0);
      check("rnd_w0", 64'(got[0]), 64'h0000_0001);
      check("rnd_w1", 64'(got[1]), 64'h8020_0003);
      check("rnd_w2", 64'(got[2]), 64'hC030_0002);
      load(2'd1, 32'h0, 1'b0, 1'b0);
      check("seed0_w0", 64'(got[0]), 64'h0000_0001);
      check("seed0_w1", 64'(got[1]), 64'h8020_0003);
      check("seed0_w2", 64'(got[2]), 64'hC030_0002);
      load(2'd2, $urandom, 1'b0, 1'b0);
      check("chk_w0", 64'(got[0]), 64'h5555_5555);
      check("chk_w3", 64'(got[3]), 64'h5555_5555);
      check("chk_w4", 64'(got[4]), 64'hAAAA_AAAA);
      check("chk_w7", 64'(got[7]), 64'hAAAA_AAAA);
      check("chk_w8", 64'(got[8]), 64'h5555_5555);
      load(2'd3, $urandom, 1'b0, 1'b0);
      check("bdr_w0", 64'(got[0]), 64'hFFFF_FFFF);
      check("bdr_w3", 64'(got[3]), 64'hFFFF_FFFF);
      check("bdr_w12", 64'(got[12]), 64'hFFFF_FFFF);
      check("bdr_w15", 64'(got[15]), 64'hFFFF_FFFF);
      check("bdr_w4", 64'(got[4]), 64'h0000_0001);
      check("bdr_w5", 64'(got[5]), 64'h0000_0000);
      check("bdr_w7", 64'(got[7]), 64'h8000_0000);
      load(2'd1, $urandom, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) load(2'($urandom_range(0, 3)), $urandom, 1'b1, i % 2 == 1);
      @(negedge clk);
      mode = 2'd1; seed = 32'hDEAD_BEEF; ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(wr_en && addr_w == AW'(4)) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("reach_cnt5", 64'(k < 50), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_addr", 64'(addr_w), 64'd0);
      check("arst_data", 64'(data_w), 64'd0);
      check("arst_wr_en", 64'(wr_en), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      load(2'd1, $urandom, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
